// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared bus widths, field positions and bus layouts for the EX/MEM/WB stages
package mycpu_pkg;

    localparam int ES2MS_BUS = 172;
    localparam int MS2WS_BUS = 159;
    localparam int RF_ZIP_W  = 39;

    localparam int LD_OP_W   = 5;
    localparam int EXC_ZIP_W = 85;
    localparam int TLB_ZIP_W = 10;

    // one-hot load opcode bit positions inside ld_op = {b, bu, h, hu, w}
    localparam int LD_B  = 4;
    localparam int LD_BU = 3;
    localparam int LD_H  = 2;
    localparam int LD_HU = 1;
    localparam int LD_W  = 0;

    // except_zip[6:0] carries the exception / ertn flags that block memory issue
    localparam int EXC_FLAG_LO = 0;
    localparam int EXC_FLAG_HI = 6;

    // tlb_zip bit that marks a refetch-after-TLB-op instruction
    localparam int TLB_REFETCH = 9;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           alu_res;
        logic [LD_OP_W-1:0]    ld_op;
        logic                  req_sent;
        logic                  csr_re;
        logic                  rf_we;
        logic [4:0]            rf_waddr;
        logic [EXC_ZIP_W-1:0]  except_zip;
        logic [TLB_ZIP_W-1:0]  tlb_zip;
    } es2ms_t;

    typedef struct packed {
        logic [31:0]           vaddr;
        logic [31:0]           pc;
        logic [EXC_ZIP_W-1:0]  except_zip;
        logic [TLB_ZIP_W-1:0]  tlb_zip;
    } ms2ws_t;

    function automatic logic is_load(input logic [LD_OP_W-1:0] op);
        return |op;
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - selects and extends the byte/half/word a load returns
module load_extract
    import mycpu_pkg::*;
(
    input  logic [LD_OP_W-1:0] ld_op,
    input  logic [1:0]         addr,
    input  logic [31:0]        raw,
    output logic [31:0]        wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane, then extend according to the one-hot opcode
    always_comb begin
        case (addr)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = addr[1] ? raw[31:16] : raw[15:0];

        wdata = 32'd0;
        if (ld_op[LD_B]) begin
            wdata = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_op[LD_BU]) begin
            wdata = {24'd0, byte_sel};
        end else if (ld_op[LD_H]) begin
            wdata = {{16{half_sel[15]}}, half_sel};
        end else if (ld_op[LD_HU]) begin
            wdata = {16'd0, half_sel};
        end else if (ld_op[LD_W]) begin
            wdata = raw;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: waits for data responses, extracts load data, drops responses of flushed instructions
module mem_stage
    import mycpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es2ms_valid,
    input  logic [ES2MS_BUS-1:0] es2ms_bus,
    input  logic                 es_req_fire,
    output logic                 ms_allowin,
    output logic                 ms_ex_block,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_allowin,
    output logic                 ms2ws_valid,
    output logic [MS2WS_BUS-1:0] ms2ws_bus,
    output logic [RF_ZIP_W-1:0]  ms_rf_zip,
    output logic [RF_ZIP_W-1:0]  ms_fwd_zip,
    input  logic                 wb_ex,
    input  logic                 ertn_flush,
    input  logic                 wb_refetch_flush
);

    logic        ms_valid_q,    ms_valid_d;
    es2ms_t      bus_q,         bus_d;
    logic        data_got_q,    data_got_d;
    logic [31:0] data_buf_q,    data_buf_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        flush;
    logic        cnt_zero;
    logic        data_ok_live;
    logic        ms_ready_go;
    logic        ms_enter;
    logic        capture;
    logic        inc_live;
    logic        inc_ex;
    logic        dec_dead;
    logic [2:0]  discard_sum;
    logic [31:0] raw_data;
    logic [31:0] ld_wdata;
    logic [31:0] rf_wdata;
    logic        ld_pending;
    ms2ws_t      ms2ws;

    assign flush        = wb_ex | ertn_flush | wb_refetch_flush;
    assign cnt_zero     = (discard_cnt_q == 2'd0);
    // a response only belongs to the resident instruction once all dead responses have drained
    assign data_ok_live = data_sram_data_ok & cnt_zero;

    assign ms_ready_go  = ~bus_q.req_sent | data_got_q | data_ok_live;
    assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_enter     = es2ms_valid & ms_allowin & ~flush;
    assign ms2ws_valid  = ms_valid_q & ms_ready_go;

    // park the response only when WB cannot take it this cycle
    assign capture = data_sram_data_ok & ms_valid_q & bus_q.req_sent & ~data_got_q
                   & cnt_zero & ~ws_allowin;

    // responses still owed to instructions killed by this flush
    assign inc_live = flush & ms_valid_q & bus_q.req_sent & ~data_got_q & ~data_ok_live;
    assign inc_ex   = flush & es_req_fire & ~(cnt_zero & data_sram_data_ok & ~ms_valid_q);
    assign dec_dead = data_sram_data_ok & ~cnt_zero;

    // next-state for stage valid, bus latch, response buffer and discard counter
    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        data_got_d  = data_got_q;
        data_buf_d  = data_buf_q;

        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es2ms_valid;
        end

        if (ms_enter) begin
            bus_d = es2ms_bus;
        end

        if (flush || ms_enter) begin
            data_got_d = 1'b0;
            data_buf_d = 32'd0;
        end else if (capture) begin
            data_got_d = 1'b1;
            data_buf_d = data_sram_rdata;
        end

        discard_sum   = {1'b0, discard_cnt_q} + {2'b00, inc_live} + {2'b00, inc_ex}
                      - {2'b00, dec_dead};
        discard_cnt_d = discard_sum[1:0];
    end

    // state registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            bus_q         <= '0;
            data_got_q    <= 1'b0;
            data_buf_q    <= 32'd0;
            discard_cnt_q <= 2'd0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            bus_q         <= bus_d;
            data_got_q    <= data_got_d;
            data_buf_q    <= data_buf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign raw_data = data_got_q ? data_buf_q : data_sram_rdata;

    load_extract u_load_extract (
        .ld_op (bus_q.ld_op),
        .addr  (bus_q.alu_res[1:0]),
        .raw   (raw_data),
        .wdata (ld_wdata)
    );

    assign rf_wdata   = is_load(bus_q.ld_op) ? ld_wdata : bus_q.alu_res;
    assign ld_pending = ms_valid_q & is_load(bus_q.ld_op) & ~ms_ready_go;

    assign ms2ws.vaddr      = bus_q.alu_res;
    assign ms2ws.pc         = bus_q.pc;
    assign ms2ws.except_zip = bus_q.except_zip;
    assign ms2ws.tlb_zip    = bus_q.tlb_zip;
    assign ms2ws_bus        = ms2ws;

    assign ms_rf_zip  = {bus_q.csr_re, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
    assign ms_fwd_zip = {ld_pending, bus_q.rf_we & ms_valid_q, bus_q.rf_waddr, rf_wdata};

    assign ms_ex_block = ms_valid_q & (|bus_q.except_zip[EXC_FLAG_HI:EXC_FLAG_LO]
                                       | bus_q.tlb_zip[TLB_REFETCH]);

    a_discard_bound: assert property (@(posedge clk) disable iff (!resetn)
        discard_sum <= 3'd2);

    a_data_ok_owner: assert property (@(posedge clk) disable iff (!resetn)
        data_ok_live |-> (ms_valid_q & bus_q.req_sent & ~data_got_q));

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against an instruction-level model
module tb_mem_stage;

    localparam logic [4:0] OP_B  = 5'b10000;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_H  = 5'b00100;
    localparam logic [4:0] OP_HU = 5'b00010;
    localparam logic [4:0] OP_W  = 5'b00001;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  ld_op;
        logic        mem;
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [84:0] exc;
        logic [9:0]  tlb;
        logic [31:0] mdata;
    } ins_t;

    typedef struct {
        logic [31:0] data;
        bit          live;
    } resp_t;

    logic         clk;
    logic         resetn;
    logic         es2ms_valid;
    logic [171:0] es2ms_bus;
    logic         es_req_fire;
    logic         ms_allowin;
    logic         ms_ex_block;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [158:0] ms2ws_bus;
    logic [38:0]  ms_rf_zip;
    logic [38:0]  ms_fwd_zip;
    logic         wb_ex;
    logic         ertn_flush;
    logic         wb_refetch_flush;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es2ms_valid       (es2ms_valid),
        .es2ms_bus         (es2ms_bus),
        .es_req_fire       (es_req_fire),
        .ms_allowin        (ms_allowin),
        .ms_ex_block       (ms_ex_block),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms2ws_valid       (ms2ws_valid),
        .ms2ws_bus         (ms2ws_bus),
        .ms_rf_zip         (ms_rf_zip),
        .ms_fwd_zip        (ms_fwd_zip),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .wb_refetch_flush  (wb_refetch_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int retired;

    // reference model: the single MEM slot and the in-order memory response queue
    bit          m_valid;
    ins_t        m_ins;
    bit          m_got;
    logic [31:0] m_data;
    resp_t       resp_q[$];

    logic        snap_valid;
    logic        snap_exblk;
    logic [38:0] snap_rfz;
    logic [38:0] snap_fwd;

    ins_t idle_ins;

    task automatic chk(input string tag, input logic [158:0] got, input logic [158:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk_ins(input logic [31:0] pc, input logic [31:0] alu,
                                    input logic [4:0] ld_op, input bit mem, input bit rf_we,
                                    input logic [4:0] waddr, input logic [6:0] flags,
                                    input bit refetch, input logic [31:0] mdata);
        ins_t i;
        i.pc     = pc;
        i.alu    = alu;
        i.ld_op  = ld_op;
        i.mem    = mem;
        i.csr_re = 1'($urandom_range(0, 1));
        i.rf_we  = rf_we;
        i.waddr  = waddr;
        i.exc    = {32'($urandom), 32'($urandom), 14'($urandom), flags};
        i.tlb    = {refetch, 9'($urandom)};
        i.mdata  = mdata;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        int   k;
        logic [4:0] op;
        bit   mem;
        logic [6:0] flags;
        bit   refetch;
        k = $urandom_range(0, 7);
        op = 5'd0;
        mem = 1'b0;
        flags = 7'd0;
        refetch = 1'b0;
        if (k < 3) begin
            op  = 5'b00001 << $urandom_range(0, 4);
            mem = 1'b1;
        end else if (k == 3) begin
            mem = 1'b1;
        end else if (k == 4) begin
            if ($urandom_range(0, 3) == 0) refetch = 1'b1;
            else flags = 7'b0000001 << $urandom_range(0, 6);
        end
        return mk_ins($urandom, $urandom, op, mem, 1'($urandom_range(0, 1)),
                      5'($urandom), flags, refetch, $urandom);
    endfunction

    function automatic logic [171:0] pack_ins(input ins_t i);
        return {i.pc, i.alu, i.ld_op, i.mem, i.csr_re, i.rf_we, i.waddr, i.exc, i.tlb};
    endfunction

    // register-file value the instruction should write, from the load rules in plain arithmetic
    function automatic logic [31:0] ref_wdata(input ins_t i, input logic [31:0] d);
        int v;
        int bsh;
        int hsh;
        bsh = 8 * int'(i.alu[1:0]);
        hsh = 16 * int'(i.alu[1]);
        case (i.ld_op)
            OP_B:    begin v = int'((d >> bsh) & 32'hFF);   if (v > 127)   v -= 256;   end
            OP_BU:   v = int'((d >> bsh) & 32'hFF);
            OP_H:    begin v = int'((d >> hsh) & 32'hFFFF); if (v > 32767) v -= 65536; end
            OP_HU:   v = int'((d >> hsh) & 32'hFFFF);
            OP_W:    v = int'(d);
            default: v = int'(i.alu);
        endcase
        return 32'(v);
    endfunction

    // one clock: memory/WB/flush drive, check against the model, EX drive, advance the model
    task automatic cycle(input bit want_ok, input bit wsa, input int fl_kind,
                         input bit present, input ins_t ins);
        bit ok, live_pop, fl, fire, enter, exp_valid, exp_allow, exp_ld;
        int ndead;
        logic [31:0] rd;
        logic [31:0] wd;
        ok = want_ok && (resp_q.size() > 0);
        rd = $urandom;
        live_pop = 1'b0;
        if (ok) begin
            rd = resp_q[0].data;
            live_pop = resp_q[0].live;
        end
        ndead = resp_q.size() - (ok ? 1 : 0);
        fl = (fl_kind != 0) && (ndead <= 2);

        data_sram_data_ok = ok;
        data_sram_rdata   = rd;
        ws_allowin        = wsa;
        wb_ex             = fl && (fl_kind == 1);
        ertn_flush        = fl && (fl_kind == 2);
        wb_refetch_flush  = fl && (fl_kind == 3);
        es2ms_valid       = 1'b0;
        es_req_fire       = 1'b0;
        es2ms_bus         = '0;
        #1;

        if (live_pop) begin
            m_got  = 1'b1;
            m_data = rd;
        end
        exp_valid = m_valid && (!m_ins.mem || m_got);
        exp_allow = !m_valid || (exp_valid && wsa);
        exp_ld    = m_valid && (m_ins.ld_op != 5'd0) && !exp_valid;

        snap_valid = ms2ws_valid;
        snap_exblk = ms_ex_block;
        snap_rfz   = ms_rf_zip;
        snap_fwd   = ms_fwd_zip;

        if (!fl) begin
            chk("ms2ws_valid", ms2ws_valid, exp_valid);
            chk("ms_allowin", ms_allowin, exp_allow);
            chk("ms_ex_block", ms_ex_block,
                m_valid && ((|m_ins.exc[6:0]) || m_ins.tlb[9]));
            chk("fwd_ld_pending", ms_fwd_zip[38], exp_ld);
            chk("fwd_we", ms_fwd_zip[37], m_valid && m_ins.rf_we);
            if (exp_valid) begin
                wd = ref_wdata(m_ins, m_data);
                chk("ms2ws_bus", ms2ws_bus, {m_ins.alu, m_ins.pc, m_ins.exc, m_ins.tlb});
                chk("ms_rf_zip", ms_rf_zip, {m_ins.csr_re, m_ins.rf_we, m_ins.waddr, wd});
                chk("ms_fwd_zip", ms_fwd_zip, {1'b0, m_ins.rf_we, m_ins.waddr, wd});
            end
        end

        fire  = 1'b0;
        enter = 1'b0;
        if (present) begin
            es2ms_valid = 1'b1;
            es2ms_bus   = pack_ins(ins);
            fire        = ins.mem && (fl ? (ndead <= 1) : exp_allow);
            enter       = !fl && exp_allow;
            es_req_fire = fire;
        end

        @(posedge clk);
        #1;

        if (ok) void'(resp_q.pop_front());
        if (fl) begin
            m_valid = 1'b0;
            foreach (resp_q[i]) resp_q[i].live = 1'b0;
        end else if (exp_valid && wsa) begin
            m_valid = 1'b0;
            retired++;
        end
        if (fire) resp_q.push_back('{data: ins.mdata, live: !fl});
        if (enter) begin
            m_valid = 1'b1;
            m_ins   = ins;
            m_got   = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        es2ms_valid       = 1'b0;
        es2ms_bus         = '0;
        es_req_fire       = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        ws_allowin        = 1'b0;
        wb_ex             = 1'b0;
        ertn_flush        = 1'b0;
        wb_refetch_flush  = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        m_valid = 1'b0;
        m_got   = 1'b0;
        resp_q.delete();
        #1;
        chk("rst_ms2ws_valid", ms2ws_valid, 1'b0);
        chk("rst_ms_allowin", ms_allowin, 1'b1);
        chk("rst_ms_ex_block", ms_ex_block, 1'b0);
        chk("rst_ms2ws_bus", ms2ws_bus, 159'd0);
        chk("rst_ms_rf_zip", ms_rf_zip, 39'd0);
        chk("rst_ms_fwd_zip", ms_fwd_zip, 39'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() > 0 || m_valid) && n < 50) begin
            cycle(1'b1, 1'b1, 0, 1'b0, idle_ins);
            n++;
        end
        chk("drain_done", (resp_q.size() == 0 && !m_valid), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        ins_t t;
        checks  = 0;
        errors  = 0;
        retired = 0;
        idle_ins = mk_ins(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 7'd0, 1'b0, 32'd0);
        do_reset();

        // ld.b at 0x1003, response on the third cycle in MEM
        t = mk_ins(32'h1c00_0100, 32'h0000_1003, OP_B, 1'b1, 1'b1, 5'd7, 7'd0, 1'b0, 32'h80FF_FF7F);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        chk("ldb_wait1_valid", snap_valid, 1'b0);
        chk("ldb_wait1_pending", snap_fwd[38], 1'b1);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        chk("ldb_wait2_valid", snap_valid, 1'b0);
        cycle(1'b1, 1'b1, 0, 1'b0, idle_ins);
        chk("ldb_ok_valid", snap_valid, 1'b1);
        chk("ldb_wdata", snap_rfz[31:0], 32'hFFFF_FF80);

        // ld.hu at 0x2002 with WB stalled around the response
        drain();
        r0 = retired;
        t = mk_ins(32'h1c00_0200, 32'h0000_2002, OP_HU, 1'b1, 1'b1, 5'd9, 7'd0, 1'b0, 32'h8001_1234);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b1, 1'b0, 0, 1'b0, idle_ins);
        chk("lhu_ok_wdata", snap_rfz[31:0], 32'h0000_8001);
        cycle(1'b0, 1'b0, 0, 1'b0, idle_ins);
        chk("lhu_buf_valid", snap_valid, 1'b1);
        chk("lhu_buf_wdata", snap_rfz[31:0], 32'h0000_8001);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        chk("lhu_final_wdata", snap_rfz[31:0], 32'h0000_8001);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        chk("lhu_once", retired - r0, 1);

        // add: one cycle in MEM, forwarded result
        drain();
        t = mk_ins(32'h1c00_0300, 32'h0000_0042, 5'd0, 1'b0, 1'b1, 5'd5, 7'd0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        chk("add_valid", snap_valid, 1'b1);
        chk("add_fwd", snap_fwd, {1'b0, 1'b1, 5'd5, 32'h0000_0042});

        // flush with a load outstanding and another firing: two responses dropped
        drain();
        r0 = retired;
        t = mk_ins(32'h1c00_0400, 32'h0000_3000, OP_W, 1'b1, 1'b1, 5'd3, 7'd0, 1'b0, 32'h1111_1111);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        t = mk_ins(32'h1c00_0404, 32'h0000_3004, OP_W, 1'b1, 1'b1, 5'd4, 7'd0, 1'b0, 32'h2222_2222);
        cycle(1'b0, 1'b1, 1, 1'b1, t);
        t = mk_ins(32'h1c00_0500, 32'h0000_3008, OP_W, 1'b1, 1'b1, 5'd6, 7'd0, 1'b0, 32'hCAFE_F00D);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b1, 1'b1, 0, 1'b0, idle_ins);
        chk("dead1_valid", snap_valid, 1'b0);
        cycle(1'b1, 1'b1, 0, 1'b0, idle_ins);
        chk("dead2_valid", snap_valid, 1'b0);
        cycle(1'b1, 1'b1, 0, 1'b0, idle_ins);
        chk("live3_valid", snap_valid, 1'b1);
        chk("live3_wdata", snap_rfz[31:0], 32'hCAFE_F00D);
        chk("discard_retired", retired - r0, 1);

        // syscall in MEM blocks EX requests until the WB flush
        drain();
        t = mk_ins(32'h1c00_0600, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 5'd0, 7'b0000100, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 0, 1'b1, t);
        cycle(1'b0, 1'b0, 0, 1'b0, idle_ins);
        chk("sys_ex_block", snap_exblk, 1'b1);
        chk("sys_valid", snap_valid, 1'b1);
        cycle(1'b0, 1'b0, 1, 1'b0, idle_ins);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        chk("sys_flushed_valid", snap_valid, 1'b0);
        chk("sys_flushed_block", snap_exblk, 1'b0);

        // reset while a load is pending, then a load must be delivered normally
        drain();
        t = mk_ins(32'h1c00_0700, 32'h0000_4001, OP_BU, 1'b1, 1'b1, 5'd2, 7'd0, 1'b0, 32'h0000_AB00);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b0, 1'b1, 0, 1'b0, idle_ins);
        do_reset();
        t = mk_ins(32'h1c00_0800, 32'h0000_5001, OP_BU, 1'b1, 1'b1, 5'd2, 7'd0, 1'b0, 32'h0000_AB00);
        cycle(1'b0, 1'b1, 0, 1'b1, t);
        cycle(1'b1, 1'b1, 0, 1'b0, idle_ins);
        chk("post_rst_valid", snap_valid, 1'b1);
        chk("post_rst_wdata", snap_rfz[31:0], 32'h0000_00AB);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) != 0),
                  (($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0),
                  ($urandom_range(0, 9) < 7), rand_ins());
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
